aq_enlarge: RTL and testbench

//  Nearest-neighbour image up-scaler: input ORG_X*ORG_Y ARGB8888 stream -> CNV_X*CNV_Y output stream.

---
 rtl/aq_enlarge_pkg.sv | 31 +++
 rtl/aq_enlarge_linebuf.sv | 39 +++
 rtl/aq_enlarge.sv | 209 ++++++++++++++++++++
 tb/tb_aq_enlarge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_enlarge_pkg.sv
// Shared definitions for the aq_enlarge nearest-neighbour up-scaler:
// FSM state encoding, pixel width and ARGB8888 field accessors.
package aq_enlarge_pkg;

    localparam int PIX_W = 32;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_DONE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    function automatic logic [7:0] pixAlpha(input pixel_t p);
        return p[31:24];
    endfunction

    function automatic logic [7:0] pixRed(input pixel_t p);
        return p[23:16];
    endfunction

    function automatic logic [7:0] pixGreen(input pixel_t p);
        return p[15:8];
    endfunction

    function automatic logic [7:0] pixBlue(input pixel_t p);
        return p[7:0];
    endfunction

endpackage

// File: rtl/aq_enlarge_linebuf.sv
// One-line pixel buffer for aq_enlarge: simple dual-port RAM with a
// write port used while filling and a 1-cycle registered read port.
// The read register only updates when a read is issued, so the last
// read pixel stays on rdData_o while the consumer is stalled.
module aq_enlarge_linebuf
    import aq_enlarge_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic             RST_N,
    input  logic             CLK,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [PIX_W-1:0] wrData_i,
    input  logic             rdEn_i,
    input  logic [AW-1:0]    rdAddr_i,
    output logic [PIX_W-1:0] rdData_o
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Storage array write port, no reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    // Registered read port; doubles as the block's output pixel register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdData_o <= '0;
        end else if (rdEn_i) begin
            rdData_o <= mem[rdAddr_i];
        end
    end

endmodule

// File: rtl/aq_enlarge.sv
// aq_enlarge: nearest-neighbour up-scaler ORG_X*ORG_Y -> CNV_X*CNV_Y.
// Buffers one input line, then replays it horizontally (X-DDA) and
// vertically (Y-DDA). Optional sink back-pressure is enabled with the
// AQ_ENLARGE_DOUT_RDY_EN macro, which adds the DOUT_RDY port.
module aq_enlarge
    import aq_enlarge_pkg::*;
#(
    parameter int MAX_X = 2048,
    parameter int AW    = 11
) (
    input  logic             RST_N,
    input  logic             CLK,
    input  logic [15:0]      ORG_X,
    input  logic [15:0]      ORG_Y,
    input  logic [15:0]      CNV_X,
    input  logic [15:0]      CNV_Y,
    input  logic             DIN_FSYNC,
    input  logic             DIN_WE,
    output logic             DIN_RDY,
    input  logic [PIX_W-1:0] DIN,
    output logic             DOUT_OE,
    output logic             DOUT_FSYNC,
    output logic             DOUT_LAST,
    output logic [PIX_W-1:0] DOUT
`ifdef AQ_ENLARGE_DOUT_RDY_EN
    ,
    input  logic             DOUT_RDY
`endif
);

    state_e state_q, state_d;

    logic [15:0]   orgX_q, orgX_d, orgY_q, orgY_d;
    logic [15:0]   cnvX_q, cnvX_d, cnvY_q, cnvY_d;
    logic [AW-1:0] wrCnt_q, wrCnt_d;
    logic [AW-1:0] srcX_q, srcX_d;
    logic [16:0]   accX_q, accX_d, accY_q, accY_d;
    logic [15:0]   col_q, col_d, row_q, row_d;
    logic          firstRead_q, firstRead_d;
    logic          oe_q, oe_d, last_q, last_d;

    logic          wrEn, rdEn, fsyncOut, stall, doutRdy;
    logic [16:0]   sumX, sumY;

`ifdef AQ_ENLARGE_DOUT_RDY_EN
    assign doutRdy = DOUT_RDY;
`else
    assign doutRdy = 1'b1;
`endif

    // A pending output pixel the sink has not taken freezes the read side.
    assign stall = oe_q & ~doutRdy;

    // Next-state logic: frame start/abort, line fill, and the X/Y DDAs.
    always_comb begin
        state_d     = state_q;
        orgX_d      = orgX_q;
        orgY_d      = orgY_q;
        cnvX_d      = cnvX_q;
        cnvY_d      = cnvY_q;
        wrCnt_d     = wrCnt_q;
        srcX_d      = srcX_q;
        accX_d      = accX_q;
        accY_d      = accY_q;
        col_d       = col_q;
        row_d       = row_q;
        firstRead_d = firstRead_q;
        oe_d        = stall;
        last_d      = stall & last_q;
        wrEn        = 1'b0;
        rdEn        = 1'b0;
        fsyncOut    = 1'b0;
        sumX        = accX_q + {1'b0, orgX_q};
        sumY        = accY_q + {1'b0, orgY_q};

        if (DIN_FSYNC) begin
            orgX_d      = ORG_X;
            orgY_d      = ORG_Y;
            cnvX_d      = (CNV_X < ORG_X) ? ORG_X : CNV_X;
            cnvY_d      = (CNV_Y < ORG_Y) ? ORG_Y : CNV_Y;
            wrCnt_d     = '0;
            srcX_d      = '0;
            accX_d      = '0;
            accY_d      = '0;
            col_d       = '0;
            row_d       = '0;
            firstRead_d = 1'b1;
            oe_d        = 1'b0;
            last_d      = 1'b0;
            if ((ORG_X != 16'd0) && (ORG_Y != 16'd0) &&
                ({16'd0, ORG_X} <= 32'(MAX_X))) begin
                state_d = ST_FILL;
            end else begin
                state_d = ST_DONE;
            end
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (DIN_WE) begin
                        wrEn = 1'b1;
                        if (16'(wrCnt_q) == orgX_q - 16'd1) begin
                            wrCnt_d = '0;
                            state_d = ST_EMIT;
                        end else begin
                            wrCnt_d = wrCnt_q + AW'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (!stall) begin
                        rdEn        = 1'b1;
                        oe_d        = 1'b1;
                        fsyncOut    = firstRead_q;
                        firstRead_d = 1'b0;
                        last_d      = (col_q == cnvX_q - 16'd1) &&
                                      (row_q == cnvY_q - 16'd1);
                        if (col_q == cnvX_q - 16'd1) begin
                            col_d  = '0;
                            srcX_d = '0;
                            accX_d = '0;
                            if (row_q == cnvY_q - 16'd1) begin
                                state_d = ST_DONE;
                            end else begin
                                row_d = row_q + 16'd1;
                                if (sumY >= {1'b0, cnvY_q}) begin
                                    accY_d  = sumY - {1'b0, cnvY_q};
                                    state_d = ST_FILL;
                                end else begin
                                    accY_d  = sumY;
                                end
                            end
                        end else begin
                            col_d = col_q + 16'd1;
                            if (sumX >= {1'b0, cnvX_q}) begin
                                accX_d = sumX - {1'b0, cnvX_q};
                                srcX_d = srcX_q + AW'(1);
                            end else begin
                                accX_d = sumX;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_DONE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latched sizes, counters, accumulators, output flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            orgX_q      <= '0;
            orgY_q      <= '0;
            cnvX_q      <= '0;
            cnvY_q      <= '0;
            wrCnt_q     <= '0;
            srcX_q      <= '0;
            accX_q      <= '0;
            accY_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            firstRead_q <= 1'b0;
            oe_q        <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            orgX_q      <= orgX_d;
            orgY_q      <= orgY_d;
            cnvX_q      <= cnvX_d;
            cnvY_q      <= cnvY_d;
            wrCnt_q     <= wrCnt_d;
            srcX_q      <= srcX_d;
            accX_q      <= accX_d;
            accY_q      <= accY_d;
            col_q       <= col_d;
            row_q       <= row_d;
            firstRead_q <= firstRead_d;
            oe_q        <= oe_d;
            last_q      <= last_d;
        end
    end

    aq_enlarge_linebuf #(
        .DEPTH (MAX_X),
        .AW    (AW)
    ) u_linebuf (
        .RST_N    (RST_N),
        .CLK      (CLK),
        .wrEn_i   (wrEn),
        .wrAddr_i (wrCnt_q),
        .wrData_i (DIN),
        .rdEn_i   (rdEn),
        .rdAddr_i (srcX_q),
        .rdData_o (DOUT)
    );

    assign DIN_RDY    = (state_q == ST_FILL);
    assign DOUT_OE    = oe_q;
    assign DOUT_LAST  = last_q;
    assign DOUT_FSYNC = fsyncOut;

endmodule

// File: tb/tb_aq_enlarge.sv
// Self-checking bench for aq_enlarge: table of frame sizes plus hand
// sequences for abort, reset mid-frame, rejected frames and (with
// AQ_ENLARGE_DOUT_RDY_EN) random sink back-pressure.
module tb_aq_enlarge;

    typedef struct {
        int ox;
        int oy;
        int cx;
        int cy;
        int expCount;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] ORG_X = '0, ORG_Y = '0, CNV_X = '0, CNV_Y = '0;
    logic        DIN_FSYNC = 1'b0, DIN_WE = 1'b0;
    logic [31:0] DIN = '0;
    logic        DIN_RDY, DOUT_OE, DOUT_FSYNC, DOUT_LAST;
    logic [31:0] DOUT;
`ifdef AQ_ENLARGE_DOUT_RDY_EN
    logic        DOUT_RDY = 1'b1;
    logic        heldValid = 1'b0, heldLast = 1'b0;
    logic [31:0] heldData = '0;
`endif

    exp_t        expQ[$];
    exp_t        e;
    logic [31:0] pix[2048];
    vec_t        tbl[8];
    int          total = 0, bad = 0;
    int          popped = 0, fsyncCnt = 0, lastCnt = 0, abortLast = 0;
    int          cyc = 0, lineEndCyc = 0, firstOeCyc = 0, fsyncCyc = 0;
    bit          abortMode = 1'b0, seenOe = 1'b0, rdyRandom = 1'b0, rdySeen = 1'b0;
    logic        rdyNow;

    aq_enlarge dut (
        .RST_N      (RST_N),
        .CLK        (CLK),
        .ORG_X      (ORG_X),
        .ORG_Y      (ORG_Y),
        .CNV_X      (CNV_X),
        .CNV_Y      (CNV_Y),
        .DIN_FSYNC  (DIN_FSYNC),
        .DIN_WE     (DIN_WE),
        .DIN_RDY    (DIN_RDY),
        .DIN        (DIN),
        .DOUT_OE    (DOUT_OE),
        .DOUT_FSYNC (DOUT_FSYNC),
        .DOUT_LAST  (DOUT_LAST),
        .DOUT       (DOUT)
`ifdef AQ_ENLARGE_DOUT_RDY_EN
        ,
        .DOUT_RDY   (DOUT_RDY)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pops, stall-hold and frame event bookkeeping.
    always @(negedge CLK) begin
        rdyNow = 1'b1;
`ifdef AQ_ENLARGE_DOUT_RDY_EN
        rdyNow = DOUT_RDY;
        if (heldValid && RST_N)
            checkOutput("stall_hold", {31'd0, DOUT_OE, DOUT_LAST, DOUT}, {31'd0, 1'b1, heldLast, heldData});
        heldValid = DOUT_OE && !DOUT_RDY && RST_N;
        heldData  = DOUT;
        heldLast  = DOUT_LAST;
`endif
        if (DOUT_OE && rdyNow) begin
            if (abortMode) begin
                if (DOUT_LAST) abortLast++;
            end else if (expQ.size() == 0) begin
                checkOutput("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("pix%0d", popped), {31'd0, DOUT_LAST, DOUT}, {31'd0, e.last, e.data});
                popped++;
                if (DOUT_LAST) lastCnt++;
            end
        end
        if (!abortMode) begin
            if (DOUT_FSYNC) begin
                fsyncCnt++;
                fsyncCyc = cyc;
            end
            if (DOUT_OE && !seenOe) begin
                seenOe     = 1'b1;
                firstOeCyc = cyc;
            end
        end
    end

`ifdef AQ_ENLARGE_DOUT_RDY_EN
    // Sink ready generator: random while enabled, otherwise always ready.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            DOUT_RDY = rdyRandom ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end
`endif

    task automatic applyStimulus(input int ox, input int oy, input int cx, input int cy);
        int cxe, cye;
        ORG_X     = ox[15:0];
        ORG_Y     = oy[15:0];
        CNV_X     = cx[15:0];
        CNV_Y     = cy[15:0];
        DIN_FSYNC = 1'b1;
        DIN_WE    = 1'b1;
        DIN       = 32'hDEAD_BEEF;
        @(posedge CLK);
        #1;
        DIN_FSYNC = 1'b0;
        DIN_WE    = 1'b0;
        expQ.delete();
        abortMode = 1'b0;
        popped    = 0;
        fsyncCnt  = 0;
        lastCnt   = 0;
        seenOe    = 1'b0;
        for (int k = 0; k < ox * oy; k++) pix[k] = $urandom;
        cxe = (cx < ox) ? ox : cx;
        cye = (cy < oy) ? oy : cy;
        for (int j = 0; j < cye; j++) begin
            for (int i = 0; i < cxe; i++) begin
                exp_t x;
                x.data = pix[(j * oy / cye) * ox + (i * ox / cxe)];
                x.last = (i == cxe - 1) && (j == cye - 1);
                expQ.push_back(x);
            end
        end
    endtask

    task automatic feed(input int ox, input int n);
        int budget;
        for (int k = 0; k < n; k++) begin
            budget = 0;
            DIN    = pix[k];
            DIN_WE = 1'b1;
            while (!DIN_RDY && budget < 3000) begin
                @(posedge CLK);
                #1;
                budget++;
            end
            if (!DIN_RDY) begin
                checkOutput("feed_timeout", 64'd0, 64'd1);
                DIN_WE = 1'b0;
                return;
            end
            if (k == ox - 1) lineEndCyc = cyc;
            @(posedge CLK);
            #1;
        end
        DIN_WE = 1'b0;
    endtask

    task automatic waitPopped(input int target, input int budget);
        int n;
        n = 0;
        while (popped < target && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
    endtask

    task automatic finishFrame(input vec_t v, input string tag);
        feed(v.ox, v.ox * v.oy);
        checkOutput({tag, "_rdy_after_fill"}, 64'(DIN_RDY), 64'd0);
        waitPopped(v.expCount, 10000);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput({tag, "_count"}, 64'(popped), 64'(v.expCount));
        checkOutput({tag, "_fsync_cnt"}, 64'(fsyncCnt), 64'd1);
        checkOutput({tag, "_last_cnt"}, 64'(lastCnt), 64'd1);
        checkOutput({tag, "_oe_latency"}, 64'(firstOeCyc - lineEndCyc), 64'd2);
        checkOutput({tag, "_fsync_lead"}, 64'(firstOeCyc - fsyncCyc), 64'd1);
        checkOutput({tag, "_idle"}, {62'd0, DIN_RDY, DOUT_OE}, 64'd0);
    endtask

    task automatic rejectFrame(input int ox, input int oy, input string tag);
        applyStimulus(ox, oy, 4, 4);
        expQ.delete();
        rdySeen = 1'b0;
        DIN_WE  = 1'b1;
        repeat (20) begin
            if (DIN_RDY) rdySeen = 1'b1;
            @(posedge CLK);
            #1;
        end
        DIN_WE = 1'b0;
        checkOutput({tag, "_rdy"}, 64'(rdySeen), 64'd0);
        checkOutput({tag, "_outputs"}, 64'(popped), 64'd0);
    endtask

    initial begin
        tbl[0] = '{2, 2, 4, 4, 16};
        tbl[1] = '{3, 1, 5, 1, 5};
        tbl[2] = '{4, 2, 4, 2, 8};
        tbl[3] = '{4, 2, 2, 1, 8};
        tbl[4] = '{3, 2, 7, 5, 35};
        tbl[5] = '{1, 1, 3, 2, 6};
        tbl[6] = '{5, 3, 6, 7, 42};
        tbl[7] = '{2048, 1, 100, 1, 2048};

        #1;
        checkOutput("reset_outputs", {29'd0, DIN_RDY, DOUT_OE, DOUT_FSYNC, DOUT_LAST, DOUT}, 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int t = 0; t < 8; t++) begin
            $display("[TB] vector %0d: %0dx%0d -> %0dx%0d", t, tbl[t].ox, tbl[t].oy, tbl[t].cx, tbl[t].cy);
            applyStimulus(tbl[t].ox, tbl[t].oy, tbl[t].cx, tbl[t].cy);
            finishFrame(tbl[t], $sformatf("vec%0d", t));
        end

        $display("[TB] abort during second output row");
        applyStimulus(2, 2, 4, 4);
        feed(2, 2);
        waitPopped(5, 200);
        checkOutput("abort_reached_row1", 64'(popped >= 5), 64'd1);
        abortMode = 1'b1;
        abortLast = 0;
        applyStimulus(2, 2, 4, 4);
        finishFrame(tbl[0], "after_abort");
        checkOutput("abort_no_last", 64'(abortLast), 64'd0);

        $display("[TB] reset asserted mid-emit");
        applyStimulus(2, 2, 4, 4);
        feed(2, 2);
        waitPopped(3, 200);
        checkOutput("reset_reached_emit", 64'(popped >= 3), 64'd1);
        abortMode = 1'b1;
        RST_N = 1'b0;
        @(negedge CLK);
        checkOutput("midreset_outputs", {29'd0, DIN_RDY, DOUT_OE, DOUT_FSYNC, DOUT_LAST, DOUT}, 64'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("postreset_rdy", 64'(DIN_RDY), 64'd0);
        applyStimulus(2, 2, 4, 4);
        finishFrame(tbl[0], "after_reset");

        $display("[TB] rejected frame sizes");
        rejectFrame(0, 2, "rej_x0");
        rejectFrame(2, 0, "rej_y0");
        rejectFrame(2049, 1, "rej_xbig");

`ifdef AQ_ENLARGE_DOUT_RDY_EN
        $display("[TB] random sink back-pressure");
        rdyRandom = 1'b1;
        applyStimulus(2, 2, 4, 4);
        finishFrame(tbl[0], "stall");
        applyStimulus(3, 2, 7, 5);
        finishFrame(tbl[4], "stall2");
        rdyRandom = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
